// File: rtl/matmul_pkg.sv
// Shared widths, arbiter state encoding and matmul control-register constants
// used by the matmul APB arbiter slice.
package matmul_pkg;

  localparam int BUS_WIDTH  = 32;
  localparam int ADDR_WIDTH = 16;
  localparam int MAX_DIM    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } arb_state_t;

  // Writing START_BIT of the control register at CTRL_ADDR kicks off a multiply.
  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR = '0;
  localparam int                    START_BIT = 0;

endpackage

// File: rtl/matmul_rr_arb2.sv
// Two-way round-robin grant: a tie goes to the requester that was not served
// last, a sole requester always wins. Purely combinational; rr_last lives in the parent.
module matmul_rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic [1:0] gnt
);

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    gnt = req;
    if (&req) begin
      gnt = rr_last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/matmul_apb_arbiter.sv
// Shares the matmul APB completer between m0 (host) and m1 (DMA/test), replaying each
// granted transfer downstream. Define MATMUL_ARB_LOCK_EN to hold the grant across a START.
module matmul_apb_arbiter #(
  parameter int BUS_WIDTH  = matmul_pkg::BUS_WIDTH,
  parameter int ADDR_WIDTH = matmul_pkg::ADDR_WIDTH,
  parameter int MAX_DIM    = matmul_pkg::MAX_DIM
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_psel_i,
  input  logic                  m0_penable_i,
  input  logic                  m0_pwrite_i,
  input  logic [MAX_DIM-1:0]    m0_pstrb_i,
  input  logic [BUS_WIDTH-1:0]  m0_pwdata_i,
  input  logic [ADDR_WIDTH-1:0] m0_paddr_i,
  output logic                  m0_pready_o,
  output logic                  m0_pslverr_o,
  output logic [BUS_WIDTH-1:0]  m0_prdata_o,
  output logic                  m0_busy_o,
  input  logic                  m1_psel_i,
  input  logic                  m1_penable_i,
  input  logic                  m1_pwrite_i,
  input  logic [MAX_DIM-1:0]    m1_pstrb_i,
  input  logic [BUS_WIDTH-1:0]  m1_pwdata_i,
  input  logic [ADDR_WIDTH-1:0] m1_paddr_i,
  output logic                  m1_pready_o,
  output logic                  m1_pslverr_o,
  output logic [BUS_WIDTH-1:0]  m1_prdata_o,
  output logic                  m1_busy_o,
  output logic                  s_psel_o,
  output logic                  s_penable_o,
  output logic                  s_pwrite_o,
  output logic [MAX_DIM-1:0]    s_pstrb_o,
  output logic [BUS_WIDTH-1:0]  s_pwdata_o,
  output logic [ADDR_WIDTH-1:0] s_paddr_o,
  input  logic                  s_pready_i,
  input  logic                  s_pslverr_i,
  input  logic [BUS_WIDTH-1:0]  s_prdata_i,
`ifdef MATMUL_ARB_LOCK_EN
  output logic                  lock_o,
`endif
  input  logic                  s_busy_i
);

  import matmul_pkg::*;

  arb_state_t            state;
  logic                  rr_last;
  logic                  grant_idx;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic                  hold_write;
  logic [BUS_WIDTH-1:0]  hold_wdata;
  logic [MAX_DIM-1:0]    hold_strb;

  logic [1:0]            req;
  logic [1:0]            req_eff;
  logic [1:0]            gnt;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_write;
  logic [BUS_WIDTH-1:0]  sel_wdata;
  logic [MAX_DIM-1:0]    sel_strb;

  assign req = {m1_psel_i, m0_psel_i};

`ifdef MATMUL_ARB_LOCK_EN
  logic lock;
  logic lock_owner;
  logic busy_seen;

  // A locked grant masks the other requester out entirely, ties included.
  assign req_eff = lock ? (req & (lock_owner ? 2'b10 : 2'b01)) : req;
  assign lock_o  = lock;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock       <= 1'b0;
      lock_owner <= 1'b0;
      busy_seen  <= 1'b0;
    end else if (state == IDLE && |gnt && sel_write &&
                 sel_addr == CTRL_ADDR && sel_wdata[START_BIT]) begin
      lock       <= 1'b1;
      lock_owner <= gnt[1];
      busy_seen  <= 1'b0;
    end else if (lock) begin
      if (s_busy_i) begin
        busy_seen <= 1'b1;
      end else if (busy_seen) begin
        lock <= 1'b0;
      end
    end
  end
`else
  assign req_eff = req;
`endif

  matmul_rr_arb2 u_rr_arb2 (
    .req     (req_eff),
    .rr_last (rr_last),
    .gnt     (gnt)
  );

  assign sel_addr  = gnt[1] ? m1_paddr_i  : m0_paddr_i;
  assign sel_write = gnt[1] ? m1_pwrite_i : m0_pwrite_i;
  assign sel_wdata = gnt[1] ? m1_pwdata_i : m0_pwdata_i;
  assign sel_strb  = gnt[1] ? m1_pstrb_i  : m0_pstrb_i;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      rr_last    <= 1'b1;
      grant_idx  <= 1'b0;
      hold_addr  <= '0;
      hold_write <= 1'b0;
      hold_wdata <= '0;
      hold_strb  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // Holding registers load only here, so s_* stay frozen through wait states.
          if (|gnt) begin
            grant_idx  <= gnt[1];
            hold_addr  <= sel_addr;
            hold_write <= sel_write;
            hold_wdata <= sel_wdata;
            hold_strb  <= sel_strb;
            state      <= SETUP;
          end
        end
        SETUP:  state <= ACCESS;
        ACCESS: begin
          if (s_pready_i) begin
            rr_last <= grant_idx;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic active;
  logic complete;
  logic m0_done;
  logic m1_done;

  assign active   = (state != IDLE);
  assign complete = (state == ACCESS) && s_pready_i;

  assign s_psel_o    = active;
  assign s_penable_o = (state == ACCESS);
  assign s_pwrite_o  = active & hold_write;
  assign s_paddr_o   = active ? hold_addr  : '0;
  assign s_pwdata_o  = active ? hold_wdata : '0;
  assign s_pstrb_o   = active ? hold_strb  : '0;

  // A requester that dropped psel/penable mid-transfer simply never sees the response.
  assign m0_done = complete && !grant_idx && m0_psel_i && m0_penable_i;
  assign m1_done = complete &&  grant_idx && m1_psel_i && m1_penable_i;

  assign m0_pready_o  = m0_done;
  assign m0_pslverr_o = m0_done & s_pslverr_i;
  assign m0_prdata_o  = m0_done ? s_prdata_i : '0;
  assign m1_pready_o  = m1_done;
  assign m1_pslverr_o = m1_done & s_pslverr_i;
  assign m1_prdata_o  = m1_done ? s_prdata_i : '0;

  assign m0_busy_o = s_busy_i;
  assign m1_busy_o = s_busy_i;

endmodule

// File: tb/tb_matmul_apb_arbiter.sv
// Directed bench for matmul_apb_arbiter: two APB requester drivers, a wait-state
// completer model and a log of downstream completions, with hand-computed expectations.
module tb_matmul_apb_arbiter;

  import matmul_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_i;
  logic                  m0_psel_i, m0_penable_i, m0_pwrite_i;
  logic [MAX_DIM-1:0]    m0_pstrb_i;
  logic [BUS_WIDTH-1:0]  m0_pwdata_i;
  logic [ADDR_WIDTH-1:0] m0_paddr_i;
  logic                  m0_pready_o, m0_pslverr_o, m0_busy_o;
  logic [BUS_WIDTH-1:0]  m0_prdata_o;
  logic                  m1_psel_i, m1_penable_i, m1_pwrite_i;
  logic [MAX_DIM-1:0]    m1_pstrb_i;
  logic [BUS_WIDTH-1:0]  m1_pwdata_i;
  logic [ADDR_WIDTH-1:0] m1_paddr_i;
  logic                  m1_pready_o, m1_pslverr_o, m1_busy_o;
  logic [BUS_WIDTH-1:0]  m1_prdata_o;
  logic                  s_psel_o, s_penable_o, s_pwrite_o;
  logic [MAX_DIM-1:0]    s_pstrb_o;
  logic [BUS_WIDTH-1:0]  s_pwdata_o;
  logic [ADDR_WIDTH-1:0] s_paddr_o;
  logic                  s_pready_i;
  logic                  s_pslverr_i;
  logic [BUS_WIDTH-1:0]  s_prdata_i;
  logic                  s_busy_i;
`ifdef MATMUL_ARB_LOCK_EN
  logic                  lock_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int wait_cfg = 0;
  int acc_cnt  = 0;
  logic [ADDR_WIDTH-1:0] served[$];

  logic [BUS_WIDTH-1:0] rd0, rd1;
  logic                 er0, er1;
  int                   lat0, lat1;

  always #5 clk = ~clk;

  matmul_apb_arbiter dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .m0_psel_i    (m0_psel_i),
    .m0_penable_i (m0_penable_i),
    .m0_pwrite_i  (m0_pwrite_i),
    .m0_pstrb_i   (m0_pstrb_i),
    .m0_pwdata_i  (m0_pwdata_i),
    .m0_paddr_i   (m0_paddr_i),
    .m0_pready_o  (m0_pready_o),
    .m0_pslverr_o (m0_pslverr_o),
    .m0_prdata_o  (m0_prdata_o),
    .m0_busy_o    (m0_busy_o),
    .m1_psel_i    (m1_psel_i),
    .m1_penable_i (m1_penable_i),
    .m1_pwrite_i  (m1_pwrite_i),
    .m1_pstrb_i   (m1_pstrb_i),
    .m1_pwdata_i  (m1_pwdata_i),
    .m1_paddr_i   (m1_paddr_i),
    .m1_pready_o  (m1_pready_o),
    .m1_pslverr_o (m1_pslverr_o),
    .m1_prdata_o  (m1_prdata_o),
    .m1_busy_o    (m1_busy_o),
    .s_psel_o     (s_psel_o),
    .s_penable_o  (s_penable_o),
    .s_pwrite_o   (s_pwrite_o),
    .s_pstrb_o    (s_pstrb_o),
    .s_pwdata_o   (s_pwdata_o),
    .s_paddr_o    (s_paddr_o),
    .s_pready_i   (s_pready_i),
    .s_pslverr_i  (s_pslverr_i),
    .s_prdata_i   (s_prdata_i),
`ifdef MATMUL_ARB_LOCK_EN
    .lock_o       (lock_o),
`endif
    .s_busy_i     (s_busy_i)
  );

  // Completer model: pready after wait_cfg access cycles.
  assign s_pready_i = s_penable_o && (acc_cnt >= wait_cfg);

  always @(posedge clk) begin
    acc_cnt <= (s_psel_o && s_penable_o && !s_pready_i) ? acc_cnt + 1 : 0;
    if (!rst_i && s_psel_o && s_penable_o && s_pready_i) served.push_back(s_paddr_o);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int id, input logic sel, input logic en, input logic wr,
                       input logic [ADDR_WIDTH-1:0] a, input logic [BUS_WIDTH-1:0] d);
    if (id == 0) begin
      m0_psel_i = sel; m0_penable_i = en; m0_pwrite_i = wr;
      m0_paddr_i = a;  m0_pwdata_i = d;   m0_pstrb_i = sel ? '1 : '0;
    end else begin
      m1_psel_i = sel; m1_penable_i = en; m1_pwrite_i = wr;
      m1_paddr_i = a;  m1_pwdata_i = d;   m1_pstrb_i = sel ? '1 : '0;
    end
  endtask

  // Full APB requester transfer; called just after a rising edge. lat counts the
  // cycle psel is first presented as cycle 1 and ends on the cycle pready is seen.
  task automatic m_xfer(input int id, input logic wr, input logic [ADDR_WIDTH-1:0] a,
                        input logic [BUS_WIDTH-1:0] d, output logic [BUS_WIDTH-1:0] rdata,
                        output logic err, output int lat);
    logic rdy;
    int   n;
    rdy = 1'b0; rdata = '0; err = 1'b0;
    drive(id, 1'b1, 1'b0, wr, a, d);
    @(posedge clk); #1;
    drive(id, 1'b1, 1'b1, wr, a, d);
    n = 2;
    while (!rdy && n < 100) begin
      @(negedge clk);
      rdy   = (id == 0) ? m0_pready_o  : m1_pready_o;
      rdata = (id == 0) ? m0_prdata_o  : m1_prdata_o;
      err   = (id == 0) ? m0_pslverr_o : m1_pslverr_o;
      if (!rdy) begin
        @(posedge clk); #1;
        n++;
      end
    end
    @(posedge clk); #1;
    drive(id, 1'b0, 1'b0, 1'b0, '0, '0);
    lat = n;
  endtask

  initial begin
    rst_i = 1'b1; s_busy_i = 1'b0; s_pslverr_i = 1'b0; s_prdata_i = '0;
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);

    // Reset state and busy passthrough.
    check("rst_s_psel",   32'(s_psel_o),    32'd0);
    check("rst_s_pen",    32'(s_penable_o), 32'd0);
    check("rst_s_paddr",  32'(s_paddr_o),   32'd0);
    check("rst_m0_rdy",   32'(m0_pready_o), 32'd0);
    check("rst_m1_rdata", 32'(m1_prdata_o), 32'd0);
    s_busy_i = 1'b1; #1;
    check("busy_m0_hi", 32'(m0_busy_o), 32'd1);
    check("busy_m1_hi", 32'(m1_busy_o), 32'd1);
    s_busy_i = 1'b0; #1;
    check("busy_m0_lo", 32'(m0_busy_o), 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(posedge clk); #1;

    // Single m0 write, zero wait states.
    fork
      m_xfer(0, 1'b1, 16'h0010, 32'h0000_00A5, rd0, er0, lat0);
      begin
        @(negedge clk);
        check("t1_c1_psel",  32'(s_psel_o),    32'd0);
        @(negedge clk);
        check("t1_c2_psel",  32'(s_psel_o),    32'd1);
        check("t1_c2_pen",   32'(s_penable_o), 32'd0);
        check("t1_c2_wdata", s_pwdata_o,       32'h0000_00A5);
        check("t1_c2_wr",    32'(s_pwrite_o),  32'd1);
        check("t1_c2_strb",  32'(s_pstrb_o),   32'hF);
        @(negedge clk);
        check("t1_c3_pen",   32'(s_penable_o), 32'd1);
        check("t1_c3_wdata", s_pwdata_o,       32'h0000_00A5);
        check("t1_c3_addr",  32'(s_paddr_o),   32'h10);
        check("t1_c3_rdy",   32'(m0_pready_o), 32'd1);
      end
    join
    check("t1_lat", 32'(lat0), 32'd3);

    // Simultaneous requests right after reset: m0 then m1.
    rst_i = 1'b1; #2; rst_i = 1'b0;
    served.delete();
    fork
      m_xfer(0, 1'b1, 16'h0030, 32'h1, rd0, er0, lat0);
      m_xfer(1, 1'b1, 16'h0040, 32'h2, rd1, er1, lat1);
    join
    check("t2_n",     32'(served.size()), 32'd2);
    check("t2_first", 32'(served[0]),     32'h30);
    check("t2_second",32'(served[1]),     32'h40);
    check("t2_lat0",  32'(lat0),          32'd3);
    check("t2_lat1",  32'(lat1),          32'd6);

    // m1 read with four wait states and an error response.
    wait_cfg = 4; s_prdata_i = 32'h0000_1234; s_pslverr_i = 1'b1;
    fork
      m_xfer(1, 1'b0, 16'h0020, 32'h0, rd1, er1, lat1);
      begin
        @(negedge clk);
        for (int c = 2; c <= 7; c++) begin
          @(negedge clk);
          check("t3_addr", 32'(s_paddr_o),  32'h20);
          check("t3_wr",   32'(s_pwrite_o), 32'd0);
          check("t3_psel", 32'(s_psel_o),   32'd1);
          if (c < 7) begin
            check("t3_wait_rdy",   32'(m1_pready_o),  32'd0);
            check("t3_wait_rdata", m1_prdata_o,       32'd0);
            check("t3_wait_err",   32'(m1_pslverr_o), 32'd0);
          end
        end
      end
    join
    check("t3_rdata", rd1,        32'h0000_1234);
    check("t3_err",   32'(er1),   32'd1);
    check("t3_lat",   32'(lat1),  32'd7);
    wait_cfg = 0; s_prdata_i = '0; s_pslverr_i = 1'b0;

    // Continuous requests from both: strict alternation.
    served.delete();
    fork
      for (int k = 0; k < 3; k++)
        m_xfer(0, 1'b1, 16'h0050 + 16'(2 * k), 32'h0, rd0, er0, lat0);
      for (int k = 0; k < 3; k++)
        m_xfer(1, 1'b1, 16'h0060 + 16'(2 * k), 32'h0, rd1, er1, lat1);
    join
    check("t4_n", 32'(served.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("t4_order%0d", i), 32'(served[i]),
            (i % 2 == 0) ? 32'h50 + 32'(i) : 32'h5F + 32'(i));

    // Reset during ACCESS: outputs drop at once and rr state restarts at m0.
    m_xfer(0, 1'b1, 16'h0066, 32'h0, rd0, er0, lat0);
    wait_cfg = 50;
    drive(1, 1'b1, 1'b0, 1'b1, 16'h0068, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b1, 1'b1, 16'h0068, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    check("t5_in_access", 32'(s_penable_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check("t5_psel",  32'(s_psel_o),    32'd0);
    check("t5_pen",   32'(s_penable_o), 32'd0);
    check("t5_wr",    32'(s_pwrite_o),  32'd0);
    check("t5_addr",  32'(s_paddr_o),   32'd0);
    check("t5_wdata", s_pwdata_o,       32'd0);
    check("t5_strb",  32'(s_pstrb_o),   32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    wait_cfg = 0;
    @(posedge clk); #1;
    served.delete();
    fork
      m_xfer(0, 1'b1, 16'h0070, 32'h0, rd0, er0, lat0);
      m_xfer(1, 1'b1, 16'h0072, 32'h0, rd1, er1, lat1);
    join
    check("t5_first", 32'(served[0]), 32'h70);

`ifdef MATMUL_ARB_LOCK_EN
    // START write from m0 locks m1 out until busy has risen and fallen.
    served.delete();
    fork
      begin
        m_xfer(0, 1'b1, 16'h0000, 32'h1, rd0, er0, lat0);
        s_busy_i = 1'b1;
        repeat (20) @(posedge clk);
        #1 s_busy_i = 1'b0;
      end
      m_xfer(1, 1'b1, 16'h0090, 32'h5, rd1, er1, lat1);
      begin
        repeat (10) @(negedge clk);
        check("t6_lock_mid", 32'(lock_o),   32'd1);
        check("t6_m1_held",  32'(s_psel_o), 32'd0);
      end
    join
    check("t6_lat1",   32'(lat1),      32'd27);
    check("t6_first",  32'(served[0]), 32'h0);
    check("t6_unlock", 32'(lock_o),    32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
